// File: rtl/riscv_apu_slave_pkg.sv
// rtl/riscv_apu_slave_pkg.sv - shared types and arithmetic helpers for the APU responder
//
// Purpose : op / latency-class enums, the result entry struct and the ALU helpers.
// Ports   : none (package).
// Macro   : RISCV_APU_SLAVE_FLAGS_EN adds a 2-bit flags field to each result entry.
package riscv_apu_slave_pkg;

  // Widths of the result entry; the top-level WTAG/WDATA parameters default to these.
  localparam int APU_WTAG  = 6;
  localparam int APU_WDATA = 32;

  typedef enum logic [1:0] {
    APU_OP_ADD = 2'd0,
    APU_OP_SUB = 2'd1,
    APU_OP_MUL = 2'd2,
    APU_OP_MIN = 2'd3
  } apu_op_e;

  typedef enum logic [1:0] {
    APU_LAT_0    = 2'd0,
    APU_LAT_1    = 2'd1,
    APU_LAT_2    = 2'd2,
    APU_LAT_ITER = 2'd3
  } apu_lat_e;

  typedef struct packed {
    logic [APU_WDATA-1:0] data;
    logic [APU_WTAG-1:0]  tag;
`ifdef RISCV_APU_SLAVE_FLAGS_EN
    logic [1:0]           flags;
`endif
  } apu_entry_t;

  function automatic logic [APU_WDATA-1:0] apu_alu(
    input apu_op_e              op,
    input logic [APU_WDATA-1:0] a,
    input logic [APU_WDATA-1:0] b
  );
    logic [APU_WDATA-1:0] res;
    res = '0;
    case (op)
      APU_OP_ADD: res = a + b;
      APU_OP_SUB: res = a - b;
      // The low half of a signed product equals the low half of the unsigned one.
      APU_OP_MUL: res = a * b;
      APU_OP_MIN: res = ($signed(a) < $signed(b)) ? a : b;
      default:    res = '0;
    endcase
    return res;
  endfunction

`ifdef RISCV_APU_SLAVE_FLAGS_EN
  // bit0: result zero, bit1: signed overflow (ADD/SUB only).
  function automatic logic [1:0] apu_flags(
    input apu_op_e              op,
    input logic [APU_WDATA-1:0] a,
    input logic [APU_WDATA-1:0] b,
    input logic [APU_WDATA-1:0] res
  );
    logic ovf;
    ovf = 1'b0;
    if (op == APU_OP_ADD) begin
      ovf = (a[APU_WDATA-1] == b[APU_WDATA-1]) && (res[APU_WDATA-1] != a[APU_WDATA-1]);
    end else if (op == APU_OP_SUB) begin
      ovf = (a[APU_WDATA-1] != b[APU_WDATA-1]) && (res[APU_WDATA-1] != a[APU_WDATA-1]);
    end
    return {ovf, (res == '0)};
  endfunction
`endif

endpackage

// File: rtl/riscv_apu_slave_if.sv
// rtl/riscv_apu_slave_if.sv - request/response bundle between APU dispatcher and responder
//
// Purpose : groups the req/gnt request channel and valid/ready response channel.
// Signals : apu_slave_req_i/gnt_o, op_i[1:0], lat_i[1:0], tag_i[WTAG], opa_i/opb_i[WDATA],
//           rvalid_o, ready_i, rdata_o[WDATA], rtag_o[WTAG], rflags_o[1:0] (flags build).
// Modports: master (dispatcher side), slave (responder side).
// Macro   : RISCV_APU_SLAVE_FLAGS_EN adds apu_slave_rflags_o.
interface riscv_apu_slave_if #(
  parameter int WTAG  = 6,
  parameter int WDATA = 32
);
  logic             apu_slave_req_i;
  logic             apu_slave_gnt_o;
  logic [1:0]       apu_slave_op_i;
  logic [1:0]       apu_slave_lat_i;
  logic [WTAG-1:0]  apu_slave_tag_i;
  logic [WDATA-1:0] apu_slave_opa_i;
  logic [WDATA-1:0] apu_slave_opb_i;
  logic             apu_slave_rvalid_o;
  logic             apu_slave_ready_i;
  logic [WDATA-1:0] apu_slave_rdata_o;
  logic [WTAG-1:0]  apu_slave_rtag_o;
`ifdef RISCV_APU_SLAVE_FLAGS_EN
  logic [1:0]       apu_slave_rflags_o;
`endif

  modport master (
    output apu_slave_req_i, apu_slave_op_i, apu_slave_lat_i, apu_slave_tag_i,
           apu_slave_opa_i, apu_slave_opb_i, apu_slave_ready_i,
`ifdef RISCV_APU_SLAVE_FLAGS_EN
    input  apu_slave_rflags_o,
`endif
    input  apu_slave_gnt_o, apu_slave_rvalid_o, apu_slave_rdata_o, apu_slave_rtag_o
  );

  modport slave (
    input  apu_slave_req_i, apu_slave_op_i, apu_slave_lat_i, apu_slave_tag_i,
           apu_slave_opa_i, apu_slave_opb_i, apu_slave_ready_i,
`ifdef RISCV_APU_SLAVE_FLAGS_EN
    output apu_slave_rflags_o,
`endif
    output apu_slave_gnt_o, apu_slave_rvalid_o, apu_slave_rdata_o, apu_slave_rtag_o
  );

endinterface

// File: rtl/riscv_apu_slave_fifo.sv
// rtl/riscv_apu_slave_fifo.sv - result buffer FIFO of entry structs
//
// Purpose : DEPTH-entry synchronous FIFO (DEPTH a power of two), async active-low reset.
// Ports   : clk_i, rst_ni, i_push, i_data, i_pop, o_data (head), o_count, o_empty.
module riscv_apu_slave_fifo
  import riscv_apu_slave_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = apu_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       i_push,
  input  entry_t                     i_data,
  input  logic                       i_pop,
  output entry_t                     o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      // Push and pop together (including at full) leave the count unchanged.
      if (i_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/riscv_apu_slave.sv
// rtl/riscv_apu_slave.sv - APU responder: grant, latency-class execution, in-order results
//
// Purpose : grants dispatcher requests only when buffer space is reserved and the result
//           cannot overtake an older one; results pass through per-op countdown slots into
//           the result FIFO (lat 0 is presented combinationally instead).
// Ports   : clk_i, rst_ni (async, active-low), apu (riscv_apu_slave_if.slave), busy_o.
// Macro   : RISCV_APU_SLAVE_FLAGS_EN drives apu_slave_rflags_o from per-entry flags.
module riscv_apu_slave
  import riscv_apu_slave_pkg::*;
#(
  parameter int WTAG        = APU_WTAG,
  parameter int WDATA       = APU_WDATA,
  parameter int FIFO_DEPTH  = 4,
  parameter int ITER_CYCLES = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  riscv_apu_slave_if.slave        apu,
  output logic                    busy_o
);
  localparam int CW = $clog2(ITER_CYCLES + 1);
  localparam int SW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  // One slot per possible in-flight op; credit limits in-flight ops to FIFO_DEPTH.
  logic [FIFO_DEPTH-1:0] r_slot_vld;
  logic [CW-1:0]         r_slot_cnt [FIFO_DEPTH];
  apu_entry_t            r_slot_ent [FIFO_DEPTH];
  logic [CW-1:0]         r_iter_cnt;

  apu_op_e          w_op;
  apu_lat_e         w_lat;
  apu_entry_t       w_new_ent;
  apu_entry_t       w_push_ent;
  apu_entry_t       w_fifo_head;
  apu_entry_t       w_rout;
  logic [CW-1:0]    w_new_cnt;
  logic [NW-1:0]    w_fifo_count;
  logic             w_fifo_empty;
  int               w_inflight;
  logic             w_order_ok;
  logic             w_class_ok;
  logic             w_credit_ok;
  logic             w_iter_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_gnt;
  logic             w_lat0_fire;
  logic             w_alloc;
  logic             w_rvalid;
  logic             w_found;
  logic [SW-1:0]    w_free_idx;
  logic [WDATA-1:0] w_rdata;
  logic [WTAG-1:0]  w_rtag;

  assign w_op  = apu_op_e'(apu.apu_slave_op_i);
  assign w_lat = apu_lat_e'(apu.apu_slave_lat_i);

  // Result is computed from the operands present at grant.
  always_comb begin
    w_new_ent      = '0;
    w_new_ent.data = apu_alu(w_op, apu.apu_slave_opa_i, apu.apu_slave_opb_i);
    w_new_ent.tag  = apu.apu_slave_tag_i;
`ifdef RISCV_APU_SLAVE_FLAGS_EN
    w_new_ent.flags = apu_flags(w_op, apu.apu_slave_opa_i, apu.apu_slave_opb_i, w_new_ent.data);
`endif
  end

  always_comb begin
    w_new_cnt = '0;
    case (w_lat)
      APU_LAT_1:    w_new_cnt = CW'(1);
      APU_LAT_2:    w_new_cnt = CW'(2);
      APU_LAT_ITER: w_new_cnt = CW'(ITER_CYCLES);
      default:      w_new_cnt = '0;
    endcase
  end

  // Slot scan: occupancy, the single completing slot, the first free slot and ordering.
  // An op whose countdown reaches zero this cycle has remaining time cnt-1, so the new op
  // stays behind every in-flight op exactly when new_cnt >= cnt. This lets a same-class
  // stream issue every cycle while a shorter class cannot pass a longer one.
  always_comb begin
    w_inflight = 0;
    w_order_ok = 1'b1;
    w_push     = 1'b0;
    w_push_ent = '0;
    w_found    = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_slot_vld[i]) begin
        w_inflight = w_inflight + 1;
        if (w_new_cnt < r_slot_cnt[i]) w_order_ok = 1'b0;
        // Ordering guarantees distinct completion cycles, so at most one push per cycle.
        if (r_slot_cnt[i] == CW'(1)) begin
          w_push     = 1'b1;
          w_push_ent = r_slot_ent[i];
        end
      end else if (!w_found) begin
        w_found    = 1'b1;
        w_free_idx = SW'(i);
      end
    end
  end

  assign w_credit_ok = (w_inflight + int'(w_fifo_count)) < FIFO_DEPTH;
  // The iterative unit accepts a new op in its current op's completion cycle.
  assign w_iter_ok   = (r_iter_cnt <= CW'(1));

  always_comb begin
    w_class_ok = 1'b0;
    case (w_lat)
      APU_LAT_0:    w_class_ok = (r_slot_vld == '0) && w_fifo_empty && apu.apu_slave_ready_i;
      APU_LAT_ITER: w_class_ok = w_credit_ok && w_order_ok && w_iter_ok;
      default:      w_class_ok = w_credit_ok && w_order_ok;
    endcase
  end

  // Reset gates the grant so nothing is accepted or presented while rst_ni is low.
  assign w_gnt       = rst_ni && apu.apu_slave_req_i && w_class_ok;
  assign w_lat0_fire = w_gnt && (w_lat == APU_LAT_0);
  assign w_alloc     = w_gnt && (w_lat != APU_LAT_0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_slot_vld <= '0;
      r_iter_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_slot_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (r_slot_vld[i]) begin
          r_slot_cnt[i] <= r_slot_cnt[i] - 1'b1;
          if (r_slot_cnt[i] == CW'(1)) r_slot_vld[i] <= 1'b0;
        end
      end
      // Credit guarantees a genuinely free slot whenever an op is allocated.
      if (w_alloc) begin
        r_slot_vld[w_free_idx] <= 1'b1;
        r_slot_cnt[w_free_idx] <= w_new_cnt;
      end
      if (w_gnt && (w_lat == APU_LAT_ITER)) r_iter_cnt <= CW'(ITER_CYCLES);
      else if (r_iter_cnt != '0)            r_iter_cnt <= r_iter_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_alloc) r_slot_ent[w_free_idx] <= w_new_ent;
  end

  assign w_pop = !w_fifo_empty && apu.apu_slave_ready_i;

  riscv_apu_slave_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (apu_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_data  (w_push_ent),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  // Lat 0 only fires with the FIFO empty, so the two sources never collide.
  always_comb begin
    w_rvalid = 1'b0;
    w_rout   = '0;
    if (!w_fifo_empty) begin
      w_rvalid = 1'b1;
      w_rout   = w_fifo_head;
    end else if (w_lat0_fire) begin
      w_rvalid = 1'b1;
      w_rout   = w_new_ent;
    end
  end

  assign w_rdata = w_rout.data;
  assign w_rtag  = w_rout.tag;

  assign apu.apu_slave_gnt_o    = w_gnt;
  assign apu.apu_slave_rvalid_o = w_rvalid;
  assign apu.apu_slave_rdata_o  = w_rdata;
  assign apu.apu_slave_rtag_o   = w_rtag;
`ifdef RISCV_APU_SLAVE_FLAGS_EN
  assign apu.apu_slave_rflags_o = w_rout.flags;
`endif

  assign busy_o = (r_slot_vld != '0) || !w_fifo_empty;

endmodule

// File: tb/tb_riscv_apu_slave.sv
// tb/tb_riscv_apu_slave.sv - self-checking bench for riscv_apu_slave
module tb_riscv_apu_slave;
  import riscv_apu_slave_pkg::*;

  localparam int DEPTH = 4;
  localparam int ITER  = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic busy_o;

  riscv_apu_slave_if #(.WTAG(6), .WDATA(32)) apu_if ();

  riscv_apu_slave #(
    .WTAG(6), .WDATA(32), .FIFO_DEPTH(DEPTH), .ITER_CYCLES(ITER)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .apu    (apu_if),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Model: every accepted op with the absolute cycle its countdown ends.
  typedef struct {
    int          done;
    logic [31:0] data;
    logic [5:0]  tag;
    int          cls;
  } op_t;
  op_t q[$];

  typedef struct {
    int          c;
    logic [31:0] data;
    logic [5:0]  tag;
  } log_t;
  log_t lg[$];

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'(sa * sb);
    case (op)
      0:       return a + b;
      1:       return a - b;
      2:       return p[31:0];
      default: return (sa < sb) ? a : b;
    endcase
  endfunction

  initial begin : model
    forever begin
      logic        e_gnt, e_vis, e_l0, e_rv, e_pop, was_rst;
      logic [31:0] e_data;
      logic [5:0]  e_tag;
      int          l, cd;
      op_t         nw;
      @(negedge clk_i);
      was_rst = !rst_ni;
      if (was_rst) q.delete();
      l  = int'(apu_if.apu_slave_lat_i);
      cd = (l == 3) ? ITER : l;
      e_vis = (q.size() > 0) && (cyc > q[0].done);
      e_gnt = 1'b0;
      if (!was_rst && apu_if.apu_slave_req_i) begin
        if (l == 0) e_gnt = (q.size() == 0) && apu_if.apu_slave_ready_i;
        else begin
          e_gnt = (q.size() < DEPTH);
          foreach (q[k]) begin
            if (q[k].done >= cyc && cyc + cd <= q[k].done) e_gnt = 1'b0;
            if (l == 3 && q[k].cls == 3 && q[k].done > cyc) e_gnt = 1'b0;
          end
        end
      end
      e_l0 = e_gnt && (l == 0);
      nw.done = cyc + cd;
      nw.data = ref_alu(int'(apu_if.apu_slave_op_i), apu_if.apu_slave_opa_i, apu_if.apu_slave_opb_i);
      nw.tag  = apu_if.apu_slave_tag_i;
      nw.cls  = l;
      e_rv   = e_vis || e_l0;
      e_data = e_vis ? q[0].data : nw.data;
      e_tag  = e_vis ? q[0].tag : nw.tag;
      chk("gnt", apu_if.apu_slave_gnt_o, e_gnt);
      chk("rvalid", apu_if.apu_slave_rvalid_o, e_rv);
      chk("busy", busy_o, q.size() != 0);
      if (e_rv) begin
        chk("rdata", apu_if.apu_slave_rdata_o, e_data);
        chk("rtag", apu_if.apu_slave_rtag_o, e_tag);
      end
      if (was_rst) begin
        chk("rst_rdata", apu_if.apu_slave_rdata_o, 0);
        chk("rst_rtag", apu_if.apu_slave_rtag_o, 0);
      end
      if (apu_if.apu_slave_rvalid_o && apu_if.apu_slave_ready_i)
        lg.push_back('{cyc, apu_if.apu_slave_rdata_o, apu_if.apu_slave_rtag_o});
      e_pop = e_vis && apu_if.apu_slave_ready_i;
      @(posedge clk_i);
      if (!was_rst) begin
        if (e_pop) void'(q.pop_front());
        if (e_gnt && l != 0) q.push_back(nw);
      end
      cyc++;
    end
  end

  task automatic drive(input int op, input int lat, input int tag, input logic [31:0] a, input logic [31:0] b);
    apu_if.apu_slave_req_i = 1'b1;
    apu_if.apu_slave_op_i  = 2'(op);
    apu_if.apu_slave_lat_i = 2'(lat);
    apu_if.apu_slave_tag_i = 6'(tag);
    apu_if.apu_slave_opa_i = a;
    apu_if.apu_slave_opb_i = b;
  endtask

  task automatic wait_gnt(output int tg);
    int n;
    n  = 0;
    tg = -1;
    while (tg < 0 && n < 40) begin
      @(negedge clk_i);
      if (apu_if.apu_slave_gnt_o === 1'b1) tg = cyc;
      n++;
    end
    if (tg < 0) begin
      total++;
      bad++;
      $display("FAIL gnt_timeout cyc=%0d actual=no_grant required=grant", cyc);
    end
    @(posedge clk_i);
    #1;
    apu_if.apu_slave_req_i = 1'b0;
  endtask

  task automatic issue(input int op, input int lat, input int tag, input logic [31:0] a,
                       input logic [31:0] b, output int tg);
    drive(op, lat, tag, a, b);
    wait_gnt(tg);
  endtask

  task automatic at_cycle(input int n);
    int k;
    k = 0;
    while (k < 200) begin
      @(negedge clk_i);
      if (cyc >= n) break;
      k++;
    end
  endtask

  function automatic int find_log(input int tag);
    foreach (lg[i]) if (int'(lg[i].tag) == tag) return i;
    return -1;
  endfunction

  task automatic chk_log(input string name, input int tag, input int exp_c, input logic [31:0] exp_d);
    int i;
    i = find_log(tag);
    if (i < 0) chk({name, "_found"}, 0, 1);
    else begin
      chk({name, "_cyc"}, lg[i].c, exp_c);
      chk({name, "_data"}, lg[i].data, exp_d);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin : stim
    int tg, t2, t3, t4, t5, t20, t21, r, t14, t30, t31, t32;
    int tk[4];
    apu_if.apu_slave_req_i   = 1'b0;
    apu_if.apu_slave_op_i    = 2'd0;
    apu_if.apu_slave_lat_i   = 2'd0;
    apu_if.apu_slave_tag_i   = 6'd0;
    apu_if.apu_slave_opa_i   = 32'd0;
    apu_if.apu_slave_opb_i   = 32'd0;
    apu_if.apu_slave_ready_i = 1'b0;
    rst_ni = 1'b0;
    idle(3);
    chk("reset_gnt", apu_if.apu_slave_gnt_o, 0);
    chk("reset_rvalid", apu_if.apu_slave_rvalid_o, 0);
    chk("reset_rdata", apu_if.apu_slave_rdata_o, 0);
    chk("reset_rtag", apu_if.apu_slave_rtag_o, 0);
    chk("reset_busy", busy_o, 0);
    rst_ni = 1'b1;
    apu_if.apu_slave_ready_i = 1'b1;
    idle(2);

    // lat 1 ADD 5+7 tag 9
    issue(0, 1, 9, 32'd5, 32'd7, tg);
    at_cycle(tg + 2);
    chk("add_rvalid", apu_if.apu_slave_rvalid_o, 1);
    chk("add_rdata", apu_if.apu_slave_rdata_o, 32'd12);
    chk("add_rtag", apu_if.apu_slave_rtag_o, 32'd9);
    at_cycle(tg + 3);
    chk("add_busy_low", busy_o, 0);
    idle(2);

    // lat 0 SUB 3-5 with unit idle
    issue(1, 0, 1, 32'd3, 32'd5, tg);
    chk_log("lat0_sub", 1, tg, 32'hFFFF_FFFE);
    idle(2);

    // lat 0 behind a lat 2 op
    issue(0, 2, 2, 32'd1, 32'd1, t2);
    issue(1, 0, 3, 32'd9, 32'd4, t3);
    chk("lat0_wait", t3, t2 + 4);
    chk_log("lat2_add", 2, t2 + 3, 32'd2);
    chk_log("lat0_after", 3, t3, 32'd5);
    idle(3);

    // order hazard: lat 2 MUL then lat 1 ADD
    issue(2, 2, 4, 32'd6, 32'hFFFF_FFFD, t4);
    issue(0, 1, 5, 32'd10, 32'd20, t5);
    chk("order_gnt", t5, t4 + 2);
    idle(5);
    chk_log("order_mul", 4, t4 + 3, 32'hFFFF_FFEE);
    chk_log("order_add", 5, t4 + 4, 32'd30);

    // credit: ready low, 4 accepted, 5th withheld until a pop
    apu_if.apu_slave_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) issue(0, 1, 10 + k, 32'(k), 32'd100, tk[k]);
    for (int k = 1; k < 4; k++) chk("credit_b2b", tk[k], tk[0] + k);
    drive(0, 1, 14, 32'd7, 32'd7);
    repeat (3) begin
      @(negedge clk_i);
      chk("credit_full_gnt", apu_if.apu_slave_gnt_o, 0);
    end
    @(posedge clk_i);
    #1;
    apu_if.apu_slave_ready_i = 1'b1;
    r = cyc;
    wait_gnt(t14);
    chk("credit_regnt", t14, r + 1);
    idle(6);
    for (int k = 0; k < 4; k++) chk_log("credit_order", 10 + k, r + k, 32'(k + 100));
    chk_log("credit_fifth", 14, r + 4, 32'd14);

    // iterative class
    issue(3, 3, 20, 32'hFFFF_FFFC, 32'd2, t20);
    issue(0, 3, 21, 32'd1, 32'd2, t21);
    chk("iter_gnt", t21, t20 + 8);
    idle(12);
    chk_log("iter_min", 20, t20 + 9, 32'hFFFF_FFFC);
    chk_log("iter_add", 21, t21 + 9, 32'd3);

    // lat 2 stream at one op per cycle
    for (int k = 0; k < 4; k++) issue(1, 2, 40 + k, 32'd50, 32'(k), tk[k]);
    for (int k = 1; k < 4; k++) chk("lat2_stream", tk[k], tk[0] + k);
    idle(6);
    for (int k = 0; k < 4; k++) chk_log("lat2_res", 40 + k, tk[0] + 3 + k, 32'(50 - k));

    // reset with 2 buffered and 1 in flight
    apu_if.apu_slave_ready_i = 1'b0;
    issue(0, 1, 30, 32'd1, 32'd2, t30);
    issue(0, 1, 31, 32'd3, 32'd4, t31);
    issue(3, 3, 32, 32'd5, 32'd6, t32);
    #2;
    chk("pre_rst_rvalid", apu_if.apu_slave_rvalid_o, 1);
    chk("pre_rst_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("rst_rvalid", apu_if.apu_slave_rvalid_o, 0);
    chk("rst_busy", busy_o, 0);
    idle(2);
    rst_ni = 1'b1;
    apu_if.apu_slave_ready_i = 1'b1;
    idle(15);
    for (int k = 30; k < 33; k++) chk("no_stale", find_log(k), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_apu_slave.md
# riscv_apu_slave

Responder end of the APU request/response interconnect: accepts dispatcher requests through a req/gnt handshake, executes a small integer op set at the latency class carried with each request, and returns results in strict issue order with a valid/ready response channel. It sits on the shared-unit side of the interconnect, facing one core's APU dispatcher. It grants a request only when the result is guaranteed buffer space and cannot overtake an older result.

## Interface
- WTAG, 6: tag width (destination register address, echoed back).
- WDATA, 32: operand/result width.
- FIFO_DEPTH, 4: result buffer entries (power of two, ≥2).
- ITER_CYCLES, 8: latency of the iterative class (≥3).
- clk_i  in  1  clock.
- rst_ni  in  1  reset: asynchronous, active-low.
- apu_slave_req_i  in  1  request valid.
- apu_slave_gnt_o  out  1  request accepted this cycle (combinational from req and state).
- apu_slave_op_i  in  2  op: 0 ADD, 1 SUB, 2 MUL (low WDATA bits), 3 MIN (signed).
- apu_slave_lat_i  in  2  latency class: 0 same-cycle, 1 one cycle, 2 two cycles, 3 iterative.
- apu_slave_tag_i  in  WTAG  tag.
- apu_slave_opa_i, apu_slave_opb_i  in  WDATA  operands.
- apu_slave_rvalid_o  out  1  response valid.
- apu_slave_ready_i  in  1  response accepted.
- apu_slave_rdata_o  out  WDATA  result.
- apu_slave_rtag_o  out  WTAG  tag of result.
- busy_o  out  1  any op in flight or buffered.

## Operation
- Result computed from operands at grant; carried through a delay line to the result FIFO, or bypassed to the output.
- Grant conditions (all must hold with req high):
  - credit: in_flight + fifo_count < FIFO_DEPTH;
  - order: new completion countdown > every in-flight countdown (a shorter class never passes a longer one);
  - lat 3: iterative unit idle, unless this cycle is its completion cycle;
  - lat 0: nothing in flight, FIFO empty, ready_i high; the result is presented combinationally the same cycle and never enters the FIFO.
- Countdown per in-flight op: loaded with 1, 2 or ITER_CYCLES at grant and decremented every cycle; at zero, the result is pushed into the FIFO.
- Output: FIFO head drives rvalid/rdata/rtag. Pop on rvalid & ready_i. When the FIFO is empty and an op completes with ready_i high, the result is still registered through the FIFO; there is no bypass other than lat 0.
- Simultaneous push and pop at full: allowed, and the count is unchanged. Credit accounting reserves space at grant, so push never sees full.
- Arithmetic: ADD/SUB wrap modulo 2^WDATA. MUL keeps the low WDATA bits of the signed product. MIN compares signed.
- Reset mid-operation: all in-flight and buffered results are discarded and no response is emitted.

## Timing
- Reset values: gnt_o 0 (no req), rvalid_o 0, rdata_o 0, rtag_o 0, busy_o 0.
- Grant at cycle T, ready held high: lat 0 → rvalid at T; lat 1 → rvalid at T+2; lat 2 → T+3; lat 3 → T+1+ITER_CYCLES. The +1 is the FIFO register stage.
- One grant per cycle max.
- rvalid, once high, holds with stable data/tag until ready_i.
- Throughput: a back-to-back same-class lat 1/2 stream sustains one op per cycle with ready high.

## Configuration
- RISCV_APU_SLAVE_FLAGS_EN:
  - Defined: adds output apu_slave_rflags_o[1:0] (bit0 result zero, bit1 signed overflow for ADD/SUB, 0 for MUL/MIN). The flags are stored per FIFO entry and have the same timing as rdata.
  - Undefined: the port and its storage are absent.

## Structure
- Package riscv_apu_slave_pkg holds:
  - op enum apu_op_e;
  - latency-class enum apu_lat_e;
  - the result entry struct (data, tag, optional flags).
- Sub-module riscv_apu_slave_fifo: synchronous FIFO of entry structs with push/pop/count and async reset.
- The delay line, countdowns, iterative busy counter and grant logic live in the top module.

## Test plan
- Reset, then lat 1 ADD 5+7 with tag 9 granted at T, ready high → rvalid at T+2, rdata 12, rtag 9; busy_o low at T+3.
- lat 0 SUB 3−5 with the unit idle → gnt and rvalid in the same cycle, rdata 0xFFFFFFFE. Repeat with one lat 2 op in flight → gnt 0 until it drains.
- lat 2 MUL granted at T, then lat 1 request at T+1 → gnt 0 at T+1 (order hazard), granted at T+2. Results return MUL first, then ADD.
- ready_i low with 4 lat 1 ops issued → 4 grants, 5th request gnt 0. Raising ready pops tags in issue order, and gnt reasserts the cycle after the first pop.
- lat 3 MIN(−4, 2) at T with ITER_CYCLES 8 → rvalid at T+9, rdata 0xFFFFFFFC. A second lat 3 request is withheld until T+8 and granted there.
- Assert rst_ni low with 2 ops buffered and 1 in flight → rvalid 0 immediately, busy_o 0. No stale response after release.
